// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial fetch unit that assembles 16-bit instructions.
// Drives PC strobes and hands instructions to the controller via valid/ready.
module instr_fetch #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              incr_pc,
    output logic              load_pc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              jump,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              busy
);

    localparam int IR_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        HI_REQ,
        HI_INC,
        LO_REQ,
        LO_INC,
        VALID,
        JUMP
    } state_t;

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;

    // State and instruction register; reset drops any partial fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and byte capture into the instruction register
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_en) state_d = HI_REQ;
            end
            HI_REQ: begin
                if (mem_ready) begin
                    ir_d[IR_W-1:DATA_W] = mem_rdata;
                    state_d             = HI_INC;
                end
            end
            HI_INC: state_d = LO_REQ;
            LO_REQ: begin
                if (mem_ready) begin
                    ir_d[DATA_W-1:0] = mem_rdata;
                    state_d          = LO_INC;
                end
            end
            LO_INC: state_d = VALID;
            VALID: begin
                if (ir_ready) begin
                    if (jump)          state_d = JUMP;
                    else if (fetch_en) state_d = HI_REQ;
                    else               state_d = IDLE;
                end
            end
            JUMP: state_d = fetch_en ? HI_REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every strobe is decoded from state alone, so the PC never sees
    // a combinational path from mem_ready or ir_ready.
    assign mem_rd   = (state_q == HI_REQ) || (state_q == LO_REQ);
    assign mem_addr = pc_addr;
    assign incr_pc  = (state_q == HI_INC) || (state_q == LO_INC)
                   || (state_q == JUMP);
    assign load_pc  = (state_q == JUMP);
    assign ir_valid = (state_q == VALID);
    assign busy     = (state_q != IDLE) && (state_q != VALID);
    assign opcode   = ir_q[IR_W-1 -: OP_W];
    assign ir_addr  = ir_q[ADDR_W-1:0];

endmodule
